// File: rtl/reg_file_wb_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_wb_pkg
//   Shared CPU package for the register file / write-back slice.
//   Holds the default data and address widths and the index of the
//   hard-wired zero register.
// ---------------------------------------------------------------------------
package reg_file_wb_pkg;

  localparam int DATA_W_DEF = 16;  // default register data width
  localparam int ADDR_W_DEF = 4;   // default address width (16 registers)
  localparam int REG_ZERO   = 0;   // register that always reads 0

endpackage : reg_file_wb_pkg

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
//   One pending bit per register: set when a writing instruction issues,
//   cleared when its write-back arrives, wiped by a pipeline flush.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears every pending bit
//   sb_set   in   mark sb_addr as write-back pending
//   sb_addr  in   destination being issued
//   wr_en    in   write-back strobe, clears the bit of wr_addr
//   wr_addr  in   write-back destination
//   flush    in   clear all pending bits (wins over sb_set)
//   pending  out  current pending bits, bit 0 is always 0
// ---------------------------------------------------------------------------
module wb_scoreboard
  import reg_file_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sb_set,
  input  logic [ADDR_W-1:0]    sb_addr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 flush,
  output logic [2**ADDR_W-1:0] pending
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [2**ADDR_W-1:0] pending_nxt;

  // Ordering sets the priority: clear by write-back, then a new issue to the
  // same register wins, then a flush wipes everything.
  always_comb begin
    // NOTE: start from a full default so no path through this block can infer a latch.
    pending_nxt = pending;
    if (wr_en) begin
      pending_nxt[wr_addr] = 1'b0;
    end
    if (sb_set && (sb_addr != ZERO_ADDR)) begin
      pending_nxt[sb_addr] = 1'b1;
    end
    if (flush) begin
      pending_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule : wb_scoreboard

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//   2-read / 1-write register file with write-back scoreboard. Register 0 is
//   hard-wired to zero. Reads are combinational; writes land at the edge.
//
//   Optional feature: define REG_BYPASS_EN to forward w_data_to_reg to a read
//   port addressing the register being written in the same cycle (and report
//   that port as not busy). Without it, such a read returns the old value.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   wr_en, wr_addr       write-back strobe and destination
//   w_data_to_reg        write-back data
//   rd_addr_a/b          read-port addresses
//   rd_data_a/b          read-port data
//   sb_set, sb_addr      issue of a writing instruction (marks pending)
//   flush                clear all pending marks
//   busy_a/b             read address has a pending write-back
//   stall                busy_a | busy_b
// ---------------------------------------------------------------------------
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] w_data_to_reg,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              flush,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall
);

  localparam int                NUM_REGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .flush   (flush),
    .pending (pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset on purpose (architectural zero state), which
      // keeps it in flops; drop this loop only if the array moves to RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs[wr_addr] <= w_data_to_reg;
    end
  end

  // Reads are forced to zero while rst is high so the ports are clean in the
  // reset cycle itself, not only after the edge.
  always_comb begin
    rd_data_a = (rd_addr_a == ZERO_ADDR) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == ZERO_ADDR) ? '0 : regs[rd_addr_b];
    busy_a    = pending[rd_addr_a];
    busy_b    = pending[rd_addr_b];
`ifdef REG_BYPASS_EN
    if (wr_en && (wr_addr != ZERO_ADDR) && (rd_addr_a == wr_addr)) begin
      rd_data_a = w_data_to_reg;
      busy_a    = 1'b0;
    end
    if (wr_en && (wr_addr != ZERO_ADDR) && (rd_addr_b == wr_addr)) begin
      rd_data_b = w_data_to_reg;
      busy_b    = 1'b0;
    end
`endif
    if (rst) begin
      rd_data_a = '0;
      rd_data_b = '0;
      busy_a    = 1'b0;
      busy_b    = 1'b0;
    end
  end

  assign stall = busy_a | busy_b;

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wb
//   Directed, table-driven bench for reg_file_wb (default widths 16/4).
//   Each table row is applied for one cycle: inputs are driven just after a
//   rising edge, outputs are compared on the falling edge, and the next
//   rising edge commits the row. Expected values that differ with
//   REG_BYPASS_EN are selected from the same macro.
// ---------------------------------------------------------------------------
module tb_reg_file_wb;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] w_data_to_reg;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        sb_set;
  logic [3:0]  sb_addr;
  logic        flush;
  logic        busy_a;
  logic        busy_b;
  logic        stall;

  reg_file_wb dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .w_data_to_reg (w_data_to_reg),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .sb_set        (sb_set),
    .sb_addr       (sb_addr),
    .flush         (flush),
    .busy_a        (busy_a),
    .busy_b        (busy_b),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        sb;
    logic [3:0]  sa;
    logic        fl;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_busy_a;
    logic        exp_busy_b;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
    input logic sb, input logic [3:0] sa, input logic fl,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [15:0] ea, input logic [15:0] eb,
    input logic eba, input logic ebb, input logic est);
    vec_t v;
    v.rst = r;   v.we = we; v.wa = wa; v.wd = wd;
    v.sb  = sb;  v.sa = sa; v.fl = fl;
    v.ra  = ra;  v.rb = rb;
    v.exp_a = ea; v.exp_b = eb;
    v.exp_busy_a = eba; v.exp_busy_b = ebb; v.exp_stall = est;
    return v;
  endfunction

  task automatic drive(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic sb, input logic [3:0] sa, input logic fl,
                       input logic [3:0] ra, input logic [3:0] rb);
    rst = r; wr_en = we; wr_addr = wa; w_data_to_reg = wd;
    sb_set = sb; sb_addr = sa; flush = fl;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                r  we wa     wd        sb sa     fl ra     rb     exp_a                  exp_b                  ba    bb    stall
    // reset cycle (ports forced quiet), then reset state of 3 and 15
    vecs.push_back(mk(1, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd3,  4'd15, 16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd3,  4'd15, 16'h0000,              16'h0000,              0,    0,    0));
    // write 5 = BEEF, seen next cycle; write to 0 ignored
    vecs.push_back(mk(0, 1, 4'd5,  16'hBEEF, 0, 4'd0,  0, 4'd5,  4'd0,  BYP ? 16'hBEEF : 16'h0, 16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 1, 4'd0,  16'h1234, 0, 4'd0,  0, 4'd5,  4'd0,  16'hBEEF,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd0,  4'd5,  16'h0000,              16'hBEEF,              0,    0,    0));
    // issue to 7, busy next cycle on both ports, cleared by its write-back
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 1, 4'd7,  0, 4'd7,  4'd7,  16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd7,  4'd7,  16'h0000,              16'h0000,              1,    1,    1));
    vecs.push_back(mk(0, 1, 4'd7,  16'h00A5, 0, 4'd0,  0, 4'd0,  4'd7,  16'h0000,              BYP ? 16'h00A5 : 16'h0, 0,    !BYP, !BYP));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd0,  4'd7,  16'h0000,              16'h00A5,              0,    0,    0));
    // same-cycle issue and write-back to 4: data written, bit stays set; flush clears
    vecs.push_back(mk(0, 1, 4'd4,  16'h0011, 1, 4'd4,  0, 4'd4,  4'd0,  BYP ? 16'h0011 : 16'h0, 16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd4,  4'd4,  16'h0011,              16'h0011,              1,    1,    1));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  1, 4'd4,  4'd0,  16'h0011,              16'h0000,              1,    0,    1));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd4,  4'd0,  16'h0011,              16'h0000,              0,    0,    0));
    // issue to register 0 ignored
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 1, 4'd0,  0, 4'd0,  4'd0,  16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd0,  4'd0,  16'h0000,              16'h0000,              0,    0,    0));
    // bypass case on 9 with a pending bit
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 1, 4'd9,  0, 4'd9,  4'd0,  16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 1, 4'd9,  16'h5A5A, 0, 4'd0,  0, 4'd9,  4'd9,  BYP ? 16'h5A5A : 16'h0, BYP ? 16'h5A5A : 16'h0, !BYP, !BYP, !BYP));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd9,  4'd0,  16'h5A5A,              16'h0000,              0,    0,    0));
    // flush beats same-cycle issue; simultaneous write-back still writes
    vecs.push_back(mk(0, 1, 4'd3,  16'h3333, 1, 4'd3,  1, 4'd3,  4'd9,  BYP ? 16'h3333 : 16'h0, 16'h5A5A,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd3,  4'd9,  16'h3333,              16'h5A5A,              0,    0,    0));
    // write 2 = FFFF and issue 6, then reset wipes both; write-back in reset cycle lost
    vecs.push_back(mk(0, 1, 4'd2,  16'hFFFF, 1, 4'd6,  0, 4'd2,  4'd6,  BYP ? 16'hFFFF : 16'h0, 16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd2,  4'd6,  16'hFFFF,              16'h0000,              0,    1,    1));
    vecs.push_back(mk(1, 1, 4'd8,  16'h8888, 1, 4'd8,  1, 4'd2,  4'd6,  16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd2,  4'd6,  16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd8,  4'd8,  16'h0000,              16'h0000,              0,    0,    0));
    vecs.push_back(mk(0, 0, 4'd0,  16'h0000, 0, 4'd0,  0, 4'd5,  4'd7,  16'h0000,              16'h0000,              0,    0,    0));

    drive(1, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd0, 4'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].sb, vecs[i].sa, vecs[i].fl, vecs[i].ra, vecs[i].rb);
      @(negedge clk);
      check($sformatf("v%0d rd_data_a", i), 32'(rd_data_a), 32'(vecs[i].exp_a));
      check($sformatf("v%0d rd_data_b", i), 32'(rd_data_b), 32'(vecs[i].exp_b));
      check($sformatf("v%0d busy_a", i),    32'(busy_a),    32'(vecs[i].exp_busy_a));
      check($sformatf("v%0d busy_b", i),    32'(busy_b),    32'(vecs[i].exp_busy_b));
      check($sformatf("v%0d stall", i),     32'(stall),     32'(vecs[i].exp_stall));
      next_cycle();
    end

    // Fill every register with a distinct pattern, then read both ports back.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'(i), 16'(i * 16'h1011) ^ 16'hA000, 0, 4'd0, 0, 4'd0, 4'd0);
      next_cycle();
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      exp_a = (i == 0) ? 16'h0 : (16'(i * 16'h1011) ^ 16'hA000);
      exp_b = (i == 15) ? 16'h0 : (16'((15 - i) * 16'h1011) ^ 16'hA000);
      drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'(i), 4'(15 - i));
      @(negedge clk);
      check($sformatf("fill a[%0d]", i), 32'(rd_data_a), 32'(exp_a));
      check($sformatf("fill b[%0d]", 15 - i), 32'(rd_data_b), 32'(exp_b));
      next_cycle();
    end

    // Issue every register, confirm all busy except 0, flush, confirm idle.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 4'd0, 16'h0, 1, 4'(i), 0, 4'd0, 4'd0);
      next_cycle();
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'(i), 4'(i));
      #1;
      check($sformatf("sb busy_a[%0d]", i), 32'(busy_a), (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("sb stall[%0d]", i),  32'(stall),  (i == 0) ? 32'd0 : 32'd1);
    end
    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 1, 4'd12, 4'd1);
    next_cycle();
    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 0, 4'd12, 4'd1);
    @(negedge clk);
    check("flush stall", 32'(stall), 32'd0);
    check("flush keeps data", 32'(rd_data_a), 32'(16'(12 * 16'h1011) ^ 16'hA000));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule : tb_reg_file_wb
